// File: rtl/sonata_pinmux_sequencer.sv
// Per-pin output-source select registers with break-before-make sequencing:
// a changed select drops the pin's OE mask, commits after BREAK_CYCLES, then restores the mask.
module sonata_pinmux_sequencer #(
    parameter int PIN_NUM      = 70,
    parameter int SRC_NUM      = 4,
    parameter int BREAK_CYCLES = 4,
    parameter int ADDR_W       = 7,
    localparam int SEL_W       = $clog2(SRC_NUM)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [SEL_W-1:0]         wdata_i,
    output logic                     gnt_o,
    output logic                     rvalid_o,
    output logic [SEL_W-1:0]         rdata_o,
    output logic                     err_o,
    output logic [PIN_NUM*SEL_W-1:0] pin_sel_o,
    output logic [PIN_NUM-1:0]       pin_oe_mask_o,
    output logic                     busy_o,
    output logic [1:0]               state_dbg_o
);

    localparam int CNT_W = (BREAK_CYCLES > 1) ? $clog2(BREAK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BREAK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BRK   = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SEL_W-1:0]  sel_q [PIN_NUM];
    logic [PIN_NUM-1:0] mask_q;
    logic [ADDR_W-1:0] pin_q;
    logic [SEL_W-1:0]  val_q;
    logic [CNT_W-1:0]  cnt_q;

    logic             rvalid_q;
    logic             err_q;
    logic [SEL_W-1:0] rdata_q;

    logic addr_bad;
    logic data_bad;
    logic acc_err;
    logic start_change;

    // Bus handshake: req_i is held until gnt_o; a request and grant in the same
    // cycle is the transfer, and exactly one rvalid_o pulse follows it next cycle.
    assign gnt_o        = req_i && (state_q == IDLE);
    assign addr_bad     = int'(addr_i) >= PIN_NUM;
    assign data_bad     = we_i && (int'(wdata_i) >= SRC_NUM);
    assign acc_err      = addr_bad || data_bad;
    assign start_change = gnt_o && we_i && !acc_err && (wdata_i != sel_q[addr_i]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_change) state_d = BRK;
            BRK:     if (cnt_q == '0) state_d = APPLY;
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A reset here drops any latched change, so nothing partial reaches sel_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PIN_NUM; i++) sel_q[i] <= '0;
            mask_q <= '1;
            pin_q  <= '0;
            val_q  <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_change) begin
                        pin_q          <= addr_i;
                        val_q          <= wdata_i;
                        cnt_q          <= CNT_LOAD;
                        mask_q[addr_i] <= 1'b0;
                    end
                end
                BRK: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    else             sel_q[pin_q] <= val_q;
                end
                APPLY:   mask_q[pin_q] <= 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt_o;
            err_q    <= gnt_o && acc_err;
            rdata_q  <= (gnt_o && !we_i && !acc_err) ? sel_q[addr_i] : '0;
        end
    end

    for (genvar g = 0; g < PIN_NUM; g++) begin : g_sel_out
        assign pin_sel_o[g*SEL_W +: SEL_W] = sel_q[g];
    end

    assign pin_oe_mask_o = mask_q;
    assign busy_o        = (state_q != IDLE);
    assign state_dbg_o   = state_q;
    assign rvalid_o      = rvalid_q;
    assign err_o         = err_q;
    assign rdata_o       = rdata_q;

endmodule
